// File: rtl/io_port_master.sv
// io_port_master: valid/ready request initiator for the port bus, with automatic
// status-port read on a rising interrupt edge.
module io_port_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC = 1,
    parameter logic [ADDR_W-1:0] IRQ_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] port_id,
    output logic [DATA_W-1:0] port_in,
    input  logic [DATA_W-1:0] port_out,
    output logic              wen,
    output logic              ren,
    input  logic              interrupt,
    output logic              irq_valid,
    output logic [DATA_W-1:0] irq_data,
    input  logic              irq_ack
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t st, st_n;
    logic [3:0] cnt, cnt_n;
    logic wr, wr_n, auto, auto_n, pend, pend_n, int_q, start_irq;
    logic ready_n, wen_n, ren_n, rsp_n, irqv_n;
    logic [ADDR_W-1:0] id_n;
    logic [DATA_W-1:0] pin_n, rdata_n, irqd_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
            cnt <= '0;
            wr <= 1'b0;
            auto <= 1'b0;
            pend <= 1'b0;
            int_q <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            port_id <= '0;
            port_in <= '0;
            wen <= 1'b0;
            ren <= 1'b0;
            irq_valid <= 1'b0;
            irq_data <= '0;
        end else begin
            st <= st_n;
            cnt <= cnt_n;
            wr <= wr_n;
            auto <= auto_n;
            pend <= pend_n;
            int_q <= interrupt;
            req_ready <= ready_n;
            rsp_valid <= rsp_n;
            rsp_rdata <= rdata_n;
            port_id <= id_n;
            port_in <= pin_n;
            wen <= wen_n;
            ren <= ren_n;
            irq_valid <= irqv_n;
            irq_data <= irqd_n;
        end
    end

    // Every output is computed here one cycle ahead and registered above.
    always_comb begin
        st_n = st;
        cnt_n = cnt;
        wr_n = wr;
        auto_n = auto;
        id_n = port_id;
        pin_n = port_in;
        wen_n = 1'b0;
        ren_n = 1'b0;
        rsp_n = 1'b0;
        rdata_n = rsp_rdata;
        irqv_n = irq_valid & ~irq_ack;
        irqd_n = irq_data;
        start_irq = 1'b0;
        case (st)
            IDLE: begin
                if (pend && !irq_valid) begin
                    start_irq = 1'b1;
                    auto_n = 1'b1;
                    wr_n = 1'b0;
                    id_n = IRQ_ADDR;
                    pin_n = '0;
                    cnt_n = 4'(SETUP_CYC - 1);
                    st_n = SETUP;
                end else if (req_valid && req_ready) begin
                    auto_n = 1'b0;
                    wr_n = req_write;
                    id_n = req_addr;
                    pin_n = req_write ? req_wdata : '0;
                    cnt_n = 4'(SETUP_CYC - 1);
                    st_n = SETUP;
                end
            end
            SETUP: begin
                st_n = (cnt == 4'd0) ? STROBE : SETUP;
                cnt_n = cnt - 4'd1;
                wen_n = (cnt == 4'd0) & wr;
                ren_n = (cnt == 4'd0) & ~wr;
            end
            STROBE: begin
                st_n = HOLD;
                cnt_n = 4'(HOLD_CYC - 1);
            end
            default: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd0) begin
                    st_n = IDLE;
                    id_n = '0;
                    pin_n = '0;
                    irqv_n = auto | irqv_n;
                    irqd_n = auto ? port_out : irq_data;
                    rsp_n = ~auto;
                    rdata_n = auto ? rsp_rdata : (wr ? '0 : port_out);
                end
            end
        endcase
    end

    // Pending interrupt is one deep; it is consumed when its auto-read starts.
    assign pend_n = (interrupt & ~int_q) | (pend & ~start_irq);
    assign ready_n = (st_n == IDLE) & ~pend_n;
endmodule

// File: tb/tb_io_port_master.sv
// tb_io_port_master: directed scenario tasks for io_port_master, default timing
// plus a SETUP_CYC=HOLD_CYC=3 instance for the mid-transaction reset case.
module tb_io_port_master;
    logic clk = 1'b0;
    logic rst, rst3, req_valid, rv3, req_write, interrupt, irq_ack;
    logic [7:0] req_addr, req_wdata, port_out;
    logic req_ready, rsp_valid, wen, ren, irq_valid;
    logic [7:0] rsp_rdata, port_id, port_in, irq_data;
    logic ready3, rsp3, wen3, ren3, irqv3;
    logic [7:0] rdata3, id3, pin3, irqd3;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    io_port_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .port_id(port_id),
        .port_in(port_in), .port_out(port_out), .wen(wen), .ren(ren),
        .interrupt(interrupt), .irq_valid(irq_valid), .irq_data(irq_data),
        .irq_ack(irq_ack)
    );

    io_port_master #(.SETUP_CYC(3), .HOLD_CYC(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(rv3), .req_ready(ready3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp3), .rsp_rdata(rdata3), .port_id(id3),
        .port_in(pin3), .port_out(port_out), .wen(wen3), .ren(ren3),
        .interrupt(1'b0), .irq_valid(irqv3), .irq_data(irqd3),
        .irq_ack(1'b0)
    );

    task automatic test_reset();
        rst = 1'b0; rst3 = 1'b0; req_valid = 1'b0; rv3 = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; port_out = '0; interrupt = 1'b0; irq_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, wen, ren, irq_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {req_ready, rsp_valid, wen, ren, irq_valid});
        end
        checks++;
        if ({port_id, port_in, rsp_rdata, irq_data} !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {port_id, port_in, rsp_rdata, irq_data});
        end
        rst = 1'b1; rst3 = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || ready3 !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b%b exp 11", req_ready, ready3);
        end
    endtask

    task automatic test_write();
        logic [7:0] eid, ein;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h05; req_wdata = 8'hCC;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            eid = (c <= 3) ? 8'h05 : 8'h00;
            ein = (c <= 3) ? 8'hCC : 8'h00;
            checks++;
            if (wen !== (c == 2) || ren !== 1'b0 || rsp_valid !== (c == 4)) begin
                errors++; $display("FAIL write_strobes c%0d got wen=%b ren=%b rsp=%b exp wen=%b ren=0 rsp=%b", c, wen, ren, rsp_valid, c == 2, c == 4);
            end
            checks++;
            if (port_id !== eid || port_in !== ein) begin
                errors++; $display("FAIL write_bus c%0d got id=%h in=%h exp id=%h in=%h", c, port_id, port_in, eid, ein);
            end
            if (c == 4) begin
                checks++;
                if (rsp_rdata !== 8'h00) begin
                    errors++; $display("FAIL write_rdata got %h exp 00", rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_read();
        @(negedge clk);
        port_out = 8'hBB;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h02; req_wdata = 8'h00;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            checks++;
            if (ren !== (c == 2) || wen !== 1'b0 || rsp_valid !== (c == 4)) begin
                errors++; $display("FAIL read_strobes c%0d got ren=%b wen=%b rsp=%b exp ren=%b wen=0 rsp=%b", c, ren, wen, rsp_valid, c == 2, c == 4);
            end
            if (c == 2) begin
                checks++;
                if (port_id !== 8'h02) begin
                    errors++; $display("FAIL read_id got %h exp 02", port_id);
                end
            end
            if (c == 4) begin
                checks++;
                if (rsp_rdata !== 8'hBB) begin
                    errors++; $display("FAIL read_rdata got %h exp BB", rsp_rdata);
                end
            end
        end
    endtask

    task automatic test_irq();
        port_out = 8'h03;
        interrupt = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            checks++;
            if (ren !== (n == 3) || rsp_valid !== 1'b0 || irq_valid !== (n >= 5)) begin
                errors++; $display("FAIL irq_seq n%0d got ren=%b rsp=%b iv=%b exp ren=%b rsp=0 iv=%b", n, ren, rsp_valid, irq_valid, n == 3, n >= 5);
            end
            if (n == 1) begin
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++; $display("FAIL irq_ready got %b exp 0", req_ready);
                end
            end
            if (n == 3) begin
                checks++;
                if (port_id !== 8'h00) begin
                    errors++; $display("FAIL irq_id got %h exp 00", port_id);
                end
            end
        end
        checks++;
        if (irq_data !== 8'h03) begin
            errors++; $display("FAIL irq_data got %h exp 03", irq_data);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        interrupt = 1'b0;
        checks++;
        if (irq_valid !== 1'b0) begin
            errors++; $display("FAIL irq_ack got %b exp 0", irq_valid);
        end
        @(negedge clk);
        checks++;
        if (irq_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL irq_after got iv=%b rdy=%b exp iv=0 rdy=1", irq_valid, req_ready);
        end
    endtask

    task automatic test_edge_during_write();
        int t_wen = 0, t_rsp = 0, t_ar = 0, t_iv = 0, t_u = 0, nrsp = 0;
        logic [7:0] first_rdata = 8'hXX, last_rdata = 8'hXX;
        port_out = 8'h66;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h07; req_wdata = 8'h5A;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                nrsp++;
                if (t_rsp == 0) begin t_rsp = n; first_rdata = rsp_rdata; end
                last_rdata = rsp_rdata;
            end
            if (wen && t_wen == 0) t_wen = n;
            if (ren && port_id == 8'h00 && t_ar == 0) t_ar = n;
            if (irq_valid && t_iv == 0) t_iv = n;
            if (port_id == 8'h09 && t_u == 0) t_u = n;
            if (n == 1) begin
                interrupt = 1'b1; req_write = 1'b0; req_addr = 8'h09; req_wdata = 8'h00;
            end
            if (port_id == 8'h09) req_valid = 1'b0;
        end
        checks++;
        if (t_wen != 2 || t_rsp != 4) begin
            errors++; $display("FAIL edge_write got wen@%0d rsp@%0d exp wen@2 rsp@4", t_wen, t_rsp);
        end
        checks++;
        if (t_ar != 6 || t_iv != 8) begin
            errors++; $display("FAIL edge_autoread got ren@%0d iv@%0d exp ren@6 iv@8", t_ar, t_iv);
        end
        checks++;
        if (t_u != 9 || nrsp != 2) begin
            errors++; $display("FAIL edge_held_req got start@%0d nrsp=%0d exp start@9 nrsp=2", t_u, nrsp);
        end
        checks++;
        if (first_rdata !== 8'h00 || last_rdata !== 8'h66 || irq_data !== 8'h66) begin
            errors++; $display("FAIL edge_data got w=%h r=%h irq=%h exp 00 66 66", first_rdata, last_rdata, irq_data);
        end
    endtask

    task automatic test_irq_merge();
        int nren = 0, waited = 0;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        interrupt = 1'b0;
        port_out = 8'h21;
        @(negedge clk);
        interrupt = 1'b1;
        while (!irq_valid && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (irq_valid !== 1'b1 || irq_data !== 8'h21) begin
            errors++; $display("FAIL merge_first got iv=%b data=%h exp iv=1 data=21", irq_valid, irq_data);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ren) nren++;
            if (k < 4) interrupt = ~interrupt;
        end
        checks++;
        if (nren != 0 || req_ready !== 1'b0 || irq_valid !== 1'b1) begin
            errors++; $display("FAIL merge_blocked got ren=%0d rdy=%b iv=%b exp ren=0 rdy=0 iv=1", nren, req_ready, irq_valid);
        end
        port_out = 8'h42;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ren) nren++;
        end
        checks++;
        if (nren != 1 || irq_valid !== 1'b1 || irq_data !== 8'h42) begin
            errors++; $display("FAIL merge_second got ren=%0d iv=%b data=%h exp ren=1 iv=1 data=42", nren, irq_valid, irq_data);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        nren = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ren) nren++;
        end
        checks++;
        if (nren != 0 || irq_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL merge_done got ren=%0d iv=%b rdy=%b exp ren=0 iv=0 rdy=1", nren, irq_valid, req_ready);
        end
        interrupt = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nrsp = 0;
        @(negedge clk);
        rv3 = 1'b1; req_write = 1'b1; req_addr = 8'h11; req_wdata = 8'h77;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) rv3 = 1'b0;
        end
        checks++;
        if (wen3 !== 1'b1 || id3 !== 8'h11) begin
            errors++; $display("FAIL mid_strobe got wen=%b id=%h exp wen=1 id=11", wen3, id3);
        end
        #2 rst3 = 1'b0;
        #1;
        checks++;
        if ({wen3, ren3, rsp3, ready3} !== 4'b0 || id3 !== 8'h00 || pin3 !== 8'h00) begin
            errors++; $display("FAIL mid_async got ctl=%b id=%h in=%h exp 0000 00 00", {wen3, ren3, rsp3, ready3}, id3, pin3);
        end
        @(negedge clk);
        rst3 = 1'b1;
        checks++;
        if (ready3 !== 1'b0) begin
            errors++; $display("FAIL mid_release got rdy=%b exp 0", ready3);
        end
        @(negedge clk);
        checks++;
        if (ready3 !== 1'b1) begin
            errors++; $display("FAIL mid_ready got rdy=%b exp 1", ready3);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp3 || wen3) nrsp++;
        end
        checks++;
        if (nrsp != 0) begin
            errors++; $display("FAIL mid_norsp got %0d exp 0", nrsp);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_irq();
        test_edge_during_write();
        test_irq_merge();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
